pe_mac_stream: RTL
==================

// Module: pe_mac_stream
// PURPOSE
//  Parametrised streaming multiply-accumulate process element for the oBTC matrix x SHA3-vector product.
//  Each beat carries WCOUNT matrix words and WCOUNT vector words. The block multiplies them lane-wise and
//  accumulates over one row of NBEATS beats, then emits the row sum. It adds valid/ready flow control,
//  row framing and a length check, and sits between the matrix/SHA3 word feeders and the HeavyHash XOR stage.
// PARAMETERS
//  WBITS    4   bits per word (matrix and vector)
//  WCOUNT   4   words (lanes) per beat
//  NBEATS   16  beats per row; row length is WCOUNT*NBEATS words
//  HH_SHIFT 10  right-shift applied to the row sum when PE_HH_SHIFT_EN is defined
//  ACC_W    derived: 2*WBITS + $clog2(WCOUNT*NBEATS) (defaults give 14); not overridable
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               asynchronous active-low reset
//  clr        in   1               synchronous abort: flush the pipeline, zero the accumulator, drop the pending result
//  in_valid   in   1               beat valid
//  in_ready   out  1               block accepts a beat when in_valid & in_ready
//  in_last    in   1               beat is the final beat of a row
//  m_data     in   WCOUNT*WBITS    matrix words; lane i = [i*WBITS +: WBITS]
//  x_data     in   WCOUNT*WBITS    vector words, same lane packing
//  out_valid  out  1               row result valid; held until out_ready
//  out_ready  in   1               consumer accepts the result when out_valid & out_ready
//  out_data   out  OUT_W           row result (OUT_W = ACC_W, or ACC_W-HH_SHIFT with PE_HH_SHIFT_EN)
//  len_err    out  1               sticky: a row was framed with a length other than NBEATS
// BEHAVIOUR
//  - Reset (rst_n=0, async): in_ready=0 while reset is asserted, then 1 in the first cycle after release.
//    out_valid=0, out_data=0, len_err=0. Accumulator, beat counter and stage valids are all 0.
//  - Pipeline, 3 stages, each with its own valid bit, no stalls inside:
//    - S0: registers m/x on acceptance.
//    - S1: registers WCOUNT unsigned products, each 2*WBITS wide.
//    - S2: sums the products into the accumulator. All adds are unsigned and zero-extended to ACC_W, so they never overflow.
//  - Latency: when the in_last beat is accepted at edge k, out_valid=1 from edge k+2. At that edge out_data is
//    loaded with (acc + sum of S1 lanes) and acc is set to 0.
//  - Flow control: in_ready drops at the edge that accepts an in_last beat. It stays 0 until the edge where
//    out_valid & out_ready, and returns to 1 in the next cycle. At most one row is in flight. Bubbles
//    (in_valid=0) are allowed anywhere inside a row and do not affect the sum.
//  - out_data and out_valid hold stable while out_ready=0.
//  - Beat counter: $clog2(NBEATS)+1 bits. It increments on each accepted beat and clears on an accepted in_last beat.
//    len_err is set when in_last is accepted with count != NBEATS-1. It is also set when a beat is accepted with
//    count == NBEATS-1 and in_last=0; in that case the counter saturates and the row keeps accumulating until in_last.
//    len_err clears only on reset or clr.
//  - clr (priority over all other sync events, including a same-cycle accept or out handshake):
//    - At the next edge it zeroes all stage valids, acc, the counter, len_err, out_valid and the pending flag.
//    - in_ready=1 in the following cycle. A beat presented with clr is discarded.
//  - Reset mid-row or mid-handshake: everything returns to the reset state; no partial result is emitted.
// CONFIGURATION
//  PE_HH_SHIFT_EN defined: out_data = row_sum[ACC_W-1:HH_SHIFT], width ACC_W-HH_SHIFT (4 by default).
//    This is the HeavyHash row reduction.
//  PE_HH_SHIFT_EN undefined: out_data = full row_sum, width ACC_W. HH_SHIFT is ignored.
// STRUCTURE
//  - Package pe_pkg holds:
//    - function pe_acc_w(wbits, wcount, nbeats) returning ACC_W;
//    - function pe_out_w(...) returning OUT_W for either build;
//    - localparam PE_PIPE_LAT = 2.
//  - Sub-module pe_mult_lane (WBITS): one registered unsigned WBITS x WBITS multiplier with a valid bit and a
//    sync flush. It is instantiated WCOUNT times for S1. The adder tree and accumulator stay in the top module.
// TESTING
//  1. Full-scale row: all words 15, 16 beats, out_ready=1.
//     -> out_valid 2 edges after the last accept; out_data=14400 (14 with PE_HH_SHIFT_EN); len_err=0.
//  2. Ramp row: lane i of beat b has m=(b+i)%16, x=1, with random in_valid gaps.
//     -> out_data equals the scoreboard sum, independent of the gap pattern.
//  3. Backpressure: out_ready=0 for 10 cycles after out_valid.
//     -> out_data stable and in_ready=0 throughout; in_ready=1 the cycle after the handshake; the next row is correct.
//  4. Length errors: in_last on beat 12 -> len_err=1, result = sum of 13 beats. Then 18 beats with in_last on
//     beat 17 -> len_err stays 1, sum of 18 beats. Then clr -> len_err=0.
//  5. clr at beat 7 of a row, with in_valid=1 in the same cycle.
//     -> no out_valid for that row; the next full row of all 1s gives 64 (0 with PE_HH_SHIFT_EN).
//  6. rst_n pulsed low mid-row and again while out_valid=1.
//     -> all outputs reset asynchronously; in_ready=1 after release; the next row is correct.

Source files
------------

// File: rtl/pe_mac_stream_pkg.sv
// Shared sizing helpers for the streaming MAC element.
// PE_HH_SHIFT_EN selects the HeavyHash-reduced output width.
package pe_pkg;

    localparam int PE_PIPE_LAT = 2;

    function automatic int pe_acc_w(input int wbits, input int wcount, input int nbeats);
        return 2 * wbits + $clog2(wcount * nbeats);
    endfunction

    function automatic int pe_out_w(input int wbits, input int wcount, input int nbeats,
                                    input int hh_shift);
`ifdef PE_HH_SHIFT_EN
        return pe_acc_w(wbits, wcount, nbeats) - hh_shift;
`else
        return pe_acc_w(wbits, wcount, nbeats) + 0 * hh_shift;
`endif
    endfunction

endpackage

// File: rtl/pe_mac_stream_if.sv
// Beat input / row-result output bundle for pe_mac_stream.
// The master drives beats and out_ready; the slave is the MAC element.
interface pe_mac_stream_if #(
    parameter int WBITS  = 4,
    parameter int WCOUNT = 4,
    parameter int OUT_W  = 14
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic [WCOUNT*WBITS-1:0] m_data;
    logic [WCOUNT*WBITS-1:0] x_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_data;
    logic                    len_err;

    modport master (
        output in_valid, in_last, m_data, x_data, out_ready,
        input  in_ready, out_valid, out_data, len_err
    );

    modport slave (
        input  in_valid, in_last, m_data, x_data, out_ready,
        output in_ready, out_valid, out_data, len_err
    );
endinterface

// File: rtl/pe_mac_stream_lane.sv
// One registered unsigned WBITS x WBITS multiplier lane with valid and sync flush.
module pe_mult_lane #(
    parameter int WBITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [WBITS-1:0]   i_a,
    input  logic [WBITS-1:0]   i_b,
    output logic               o_valid,
    output logic [2*WBITS-1:0] o_prod
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_prod  <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) o_prod <= (2*WBITS)'(i_a) * (2*WBITS)'(i_b);
        end
    end
endmodule

// File: rtl/pe_mac_stream.sv
// Streaming multiply-accumulate over one row of NBEATS beats, three-stage pipeline.
// Define PE_HH_SHIFT_EN to emit row_sum[ACC_W-1:HH_SHIFT] instead of the full sum.
module pe_mac_stream
    import pe_pkg::*;
#(
    parameter int WBITS    = 4,
    parameter int WCOUNT   = 4,
    parameter int NBEATS   = 16,
    parameter int HH_SHIFT = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    pe_mac_stream_if.slave  s
);
    localparam int ACC_W = pe_acc_w(WBITS, WCOUNT, NBEATS);
    localparam int OUT_W = pe_out_w(WBITS, WCOUNT, NBEATS, HH_SHIFT);
    localparam int CNT_W = $clog2(NBEATS) + 1;
    localparam int PW    = 2 * WBITS;

    logic                     r_in_ready, r_pend;
    logic                     r_v0, r_l0, r_l1;
    logic [WCOUNT*WBITS-1:0]  r_m, r_x;
    logic [WCOUNT-1:0]        w_v1;
    logic [WCOUNT-1:0][PW-1:0] w_prod;
    logic [ACC_W-1:0]         r_acc, w_lane_sum, w_row_sum;
    logic [OUT_W-1:0]         w_out, r_out_data;
    logic                     r_out_valid, r_len_err;
    logic [CNT_W-1:0]         r_cnt;
    logic                     w_accept, w_out_hs;

    assign w_accept = s.in_valid & r_in_ready & ~clr;
    assign w_out_hs = r_out_valid & s.out_ready;

    // S0: capture the accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0 <= 1'b0;
            r_l0 <= 1'b0;
            r_m  <= '0;
            r_x  <= '0;
        end else if (clr) begin
            r_v0 <= 1'b0;
            r_l0 <= 1'b0;
        end else begin
            r_v0 <= w_accept;
            r_l0 <= w_accept & s.in_last;
            if (w_accept) begin
                r_m <= s.m_data;
                r_x <= s.x_data;
            end
        end
    end

    // S1: per-lane products
    genvar g;
    generate
        for (g = 0; g < WCOUNT; g++) begin : g_lane
            pe_mult_lane #(.WBITS(WBITS)) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_flush (clr),
                .i_valid (r_v0),
                .i_a     (r_m[g*WBITS +: WBITS]),
                .i_b     (r_x[g*WBITS +: WBITS]),
                .o_valid (w_v1[g]),
                .o_prod  (w_prod[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   r_l1 <= 1'b0;
        else if (clr) r_l1 <= 1'b0;
        else          r_l1 <= r_l0;
    end

    always_comb begin
        w_lane_sum = '0;
        for (int i = 0; i < WCOUNT; i++) w_lane_sum = w_lane_sum + ACC_W'(w_prod[i]);
    end

    assign w_row_sum = r_acc + w_lane_sum;

`ifdef PE_HH_SHIFT_EN
    assign w_out = w_row_sum[ACC_W-1:HH_SHIFT];
`else
    assign w_out = w_row_sum;
`endif

    // S2: accumulate, and close the row when the last beat arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (clr) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_out_hs) r_out_valid <= 1'b0;
            if (w_v1[0]) begin
                if (r_l1) begin
                    r_out_data  <= w_out;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                end else begin
                    r_acc <= w_row_sum;
                end
            end
        end
    end

    // One row in flight: input closes on the last beat, reopens after the result handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= 1'b0;
            r_in_ready <= 1'b0;
        end else if (clr) begin
            r_pend     <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (w_accept & s.in_last) begin
            r_pend     <= 1'b1;
            r_in_ready <= 1'b0;
        end else if (w_out_hs) begin
            r_pend     <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= ~r_pend;
        end
    end

    // Length check; an overlong row saturates the counter and keeps summing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_len_err <= 1'b0;
        end else if (clr) begin
            r_cnt     <= '0;
            r_len_err <= 1'b0;
        end else if (w_accept) begin
            if (s.in_last) begin
                r_cnt <= '0;
                if (r_cnt != CNT_W'(NBEATS-1)) r_len_err <= 1'b1;
            end else if (r_cnt == CNT_W'(NBEATS-1)) begin
                r_len_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign s.in_ready  = r_in_ready;
    assign s.out_valid = r_out_valid;
    assign s.out_data  = r_out_data;
    assign s.len_err   = r_len_err;
endmodule
